// File: rtl/bus_decoder.sv
// Address decoder bridging a picorv32 native-bus master to NUM_SLAVES slaves,
// with exec protection, access timeout and a sticky first-fault register.
module bus_decoder #(
    parameter int unsigned                         NUM_SLAVES     = 4,
    parameter int unsigned                         DATA_WIDTH     = 32,
    parameter int unsigned                         ADDR_WIDTH     = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]    SLAVE_BASE     = {32'h2000_0000, 32'h1000_0000,
                                                                     32'h0000_1000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]    SLAVE_MASK     = {32'hFFFF_FF00, 32'hFFFF_FF00,
                                                                     32'hFFFF_F000, 32'hFFFF_F000},
    parameter logic [NUM_SLAVES-1:0]               EXEC_MASK      = 4'b0001,
    parameter int unsigned                         TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0]               ERROR_RDATA    = '0
) (
    input  logic                             clk_in,
    input  logic                             reset_in,
    input  logic                             cpu_valid_in,
    input  logic                             cpu_instr_in,
    input  logic [ADDR_WIDTH-1:0]            cpu_addr_in,
    input  logic [DATA_WIDTH-1:0]            cpu_wdata_in,
    input  logic [DATA_WIDTH/8-1:0]          cpu_wstrb_in,
    output logic                             cpu_ready_out,
    output logic [DATA_WIDTH-1:0]            cpu_rdata_out,
    output logic [NUM_SLAVES-1:0]            slave_enable_out,
    output logic                             slave_write_out,
    output logic [ADDR_WIDTH-3:0]            slave_addr_out,
    output logic [DATA_WIDTH-1:0]            slave_wdata_out,
    output logic [DATA_WIDTH/8-1:0]          slave_wstrb_out,
    input  logic [NUM_SLAVES-1:0]            slave_ready_in,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slave_rdata_in,
    output logic                             fault_out,
    output logic [1:0]                       fault_code_out,
    output logic [ADDR_WIDTH-1:0]            fault_addr_out,
    input  logic                             fault_clear_in
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;
    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_UNMAPPED = 2'b01,
        FC_EXEC     = 2'b10,
        FC_TIMEOUT  = 2'b11
    } fault_code_t;

    state_t                  state_q, state_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-3:0]   off_q, off_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    fault_q, fault_d;
    fault_code_t             fcode_q, fcode_d;
    logic [ADDR_WIDTH-1:0]   faddr_q, faddr_d;

    logic                    hit;
    logic                    exec_ok;
    logic [NUM_SLAVES-1:0]   match_sel;
    logic [ADDR_WIDTH-1:0]   masked;
    logic                    sel_ready;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic                    new_fault;
    fault_code_t             new_code;
    logic [ADDR_WIDTH-1:0]   new_addr;

    // Address decode: the first match in ascending index order wins.
    always_comb begin
        hit       = 1'b0;
        exec_ok   = 1'b0;
        match_sel = '0;
        masked    = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && ((cpu_addr_in & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])
                         == SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit          = 1'b1;
                exec_ok      = EXEC_MASK[i];
                match_sel[i] = 1'b1;
                masked       = cpu_addr_in & ~SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_comb begin
        sel_ready = |(slave_ready_in & sel_q);
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                sel_rdata = sel_rdata | slave_rdata_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        write_d    = write_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        req_addr_d = req_addr_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        new_fault  = 1'b0;
        new_code   = FC_NONE;
        new_addr   = req_addr_q;

        unique case (state_q)
            IDLE: begin
                if (cpu_valid_in) begin
                    sel_d      = match_sel;
                    write_d    = |cpu_wstrb_in;
                    off_d      = masked[ADDR_WIDTH-1:2];
                    wdata_d    = cpu_wdata_in;
                    wstrb_d    = cpu_wstrb_in;
                    req_addr_d = cpu_addr_in;
                    cnt_d      = '0;
                    if (!hit || (cpu_instr_in && !exec_ok)) begin
                        new_fault = 1'b1;
                        new_code  = hit ? FC_EXEC : FC_UNMAPPED;
                        new_addr  = cpu_addr_in;
                        rdata_d   = ERROR_RDATA;
                        state_d   = RESPOND;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (sel_ready) begin
                    rdata_d = sel_rdata;
                    state_d = RESPOND;
                end else if (cnt_q == CNT_LAST) begin
                    new_fault = 1'b1;
                    new_code  = FC_TIMEOUT;
                    rdata_d   = ERROR_RDATA;
                    state_d   = RESPOND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Clear is applied first so a fault arriving with it is still captured.
    always_comb begin
        fault_d = fault_q;
        fcode_d = fcode_q;
        faddr_d = faddr_q;
        if (fault_clear_in) begin
            fault_d = 1'b0;
            fcode_d = FC_NONE;
            faddr_d = '0;
        end
        if (new_fault && (!fault_q || fault_clear_in)) begin
            fault_d = 1'b1;
            fcode_d = new_code;
            faddr_d = new_addr;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            write_q    <= 1'b0;
            off_q      <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            req_addr_q <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            fault_q    <= 1'b0;
            fcode_q    <= FC_NONE;
            faddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            write_q    <= write_d;
            off_q      <= off_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            req_addr_q <= req_addr_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            fault_q    <= fault_d;
            fcode_q    <= fcode_d;
            faddr_q    <= faddr_d;
        end
    end

    assign cpu_ready_out    = (state_q == RESPOND);
    assign cpu_rdata_out    = rdata_q;
    assign slave_enable_out = (state_q == ACCESS) ? sel_q : '0;
    assign slave_write_out  = (state_q == ACCESS) && write_q;
    assign slave_addr_out   = off_q;
    assign slave_wdata_out  = wdata_q;
    assign slave_wstrb_out  = wstrb_q;
    assign fault_out        = fault_q;
    assign fault_code_out   = fcode_q;
    assign fault_addr_out   = faddr_q;

endmodule

// File: tb/tb_bus_decoder.sv
// Directed self-checking bench for bus_decoder with default parameters.
module tb_bus_decoder;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_valid, cpu_instr;
    logic [31:0]  cpu_addr, cpu_wdata;
    logic [3:0]   cpu_wstrb;
    logic         cpu_ready;
    logic [31:0]  cpu_rdata;
    logic [3:0]   slv_en;
    logic         slv_write;
    logic [29:0]  slv_addr;
    logic [31:0]  slv_wdata;
    logic [3:0]   slv_wstrb;
    logic [3:0]   slv_ready;
    logic [127:0] slv_rdata;
    logic         fault;
    logic [1:0]   fault_code;
    logic [31:0]  fault_addr;
    logic         fault_clear;

    int tests_run    = 0;
    int tests_failed = 0;
    int n;

    bus_decoder dut (
        .clk_in           (clk),
        .reset_in         (reset),
        .cpu_valid_in     (cpu_valid),
        .cpu_instr_in     (cpu_instr),
        .cpu_addr_in      (cpu_addr),
        .cpu_wdata_in     (cpu_wdata),
        .cpu_wstrb_in     (cpu_wstrb),
        .cpu_ready_out    (cpu_ready),
        .cpu_rdata_out    (cpu_rdata),
        .slave_enable_out (slv_en),
        .slave_write_out  (slv_write),
        .slave_addr_out   (slv_addr),
        .slave_wdata_out  (slv_wdata),
        .slave_wstrb_out  (slv_wstrb),
        .slave_ready_in   (slv_ready),
        .slave_rdata_in   (slv_rdata),
        .fault_out        (fault),
        .fault_code_out   (fault_code),
        .fault_addr_out   (fault_addr),
        .fault_clear_in   (fault_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic instr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
        cpu_valid = 1'b1;
        cpu_instr = instr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_wstrb = wstrb;
        step();
        cpu_valid = 1'b0;
        cpu_instr = 1'b0;
        cpu_addr  = 32'hFFFF_FFFF;
        cpu_wstrb = 4'hF;
    endtask

    initial begin
        reset       = 1'b1;
        cpu_valid   = 1'b0;
        cpu_instr   = 1'b0;
        cpu_addr    = '0;
        cpu_wdata   = '0;
        cpu_wstrb   = '0;
        slv_ready   = '0;
        slv_rdata   = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0013};
        fault_clear = 1'b0;
        step();
        step();
        check("rst_ready", cpu_ready, 0);
        check("rst_en", slv_en, 0);
        check("rst_write", slv_write, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_fault", {fault, fault_code, fault_addr}, 0);
        reset = 1'b0;
        step();

        // Fetch from slave0, ready in first access cycle
        slv_ready = 4'b0001;
        request(1'b1, 32'h0000_0004, 32'h0, 4'h0);
        check("f_en", slv_en, 4'b0001);
        check("f_off", slv_addr, 1);
        check("f_write", slv_write, 0);
        check("f_rdy_c1", cpu_ready, 0);
        step();
        check("f_rdy_c2", cpu_ready, 1);
        check("f_rdata", cpu_rdata, 32'h0000_0013);
        check("f_en_off", slv_en, 0);
        slv_ready = 4'b0000;
        step();
        check("f_rdy_drop", cpu_ready, 0);

        // Write to slave1, stray slave0 ready ignored, slave1 ready in 3rd cycle
        request(1'b0, 32'h0000_1008, 32'hDEAD_BEEF, 4'hF);
        check("w_en", slv_en, 4'b0010);
        check("w_write", slv_write, 1);
        check("w_off", slv_addr, 2);
        check("w_wdata", slv_wdata, 32'hDEAD_BEEF);
        check("w_wstrb", slv_wstrb, 4'hF);
        slv_ready = 4'b0001;
        step();
        check("w_c2_en", slv_en, 4'b0010);
        check("w_c2_rdy", cpu_ready, 0);
        slv_ready = 4'b0000;
        step();
        check("w_c3_en", slv_en, 4'b0010);
        slv_ready = 4'b0010;
        step();
        check("w_rdy", cpu_ready, 1);
        check("w_en_off", slv_en, 0);
        slv_ready = 4'b0000;
        step();
        check("w_rdy_width", cpu_ready, 0);

        // Unmapped read faults immediately
        request(1'b0, 32'h3000_0000, 32'h0, 4'h0);
        check("u_rdy", cpu_ready, 1);
        check("u_en", slv_en, 0);
        check("u_rdata", cpu_rdata, 0);
        check("u_fault", {fault, fault_code, fault_addr}, {1'b1, 2'b01, 32'h3000_0000});
        step();
        check("u_rdy_drop", cpu_ready, 0);

        // Exec violation while a fault is pending keeps the first fault
        request(1'b1, 32'h1000_0000, 32'h0, 4'h0);
        check("x_rdy", cpu_ready, 1);
        check("x_en", slv_en, 0);
        check("x_first_wins", {fault, fault_code, fault_addr}, {1'b1, 2'b01, 32'h3000_0000});
        step();

        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
        check("clr1", {fault, fault_code, fault_addr}, 0);

        // Timeout on slave2
        request(1'b0, 32'h1000_0000, 32'h0, 4'h0);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            if (slv_en != 4'b0100) break;
            n++;
            step();
        end
        check("t_cycles", n, 255);
        check("t_rdy", cpu_ready, 1);
        check("t_en", slv_en, 0);
        check("t_rdata", cpu_rdata, 0);
        check("t_fault", {fault, fault_code, fault_addr}, {1'b1, 2'b11, 32'h1000_0000});
        step();

        // Clear together with a new fault: the new fault is captured
        fault_clear = 1'b1;
        request(1'b0, 32'h4000_0000, 32'h0, 4'h0);
        fault_clear = 1'b0;
        check("cf_fault", {fault, fault_code, fault_addr}, {1'b1, 2'b01, 32'h4000_0000});
        step();
        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
        check("clr2", fault, 0);

        // Reset during the second access cycle
        request(1'b0, 32'h0000_0000, 32'h0, 4'h0);
        check("r_en_c1", slv_en, 4'b0001);
        step();
        check("r_en_c2", slv_en, 4'b0001);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("r_en", slv_en, 0);
        check("r_rdy", cpu_ready, 0);
        step();
        check("r_rdy_after", cpu_ready, 0);
        check("r_idle_en", slv_en, 0);

        slv_rdata[31:0] = 32'hCAFE_0008;
        slv_ready = 4'b0001;
        request(1'b0, 32'h0000_0008, 32'h0, 4'h0);
        check("r2_en", slv_en, 4'b0001);
        check("r2_off", slv_addr, 2);
        step();
        check("r2_rdy", cpu_ready, 1);
        check("r2_rdata", cpu_rdata, 32'hCAFE_0008);
        slv_ready = 4'b0000;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
